// File: rtl/ark_pkg.sv
// Shared types and constants for the AES AddRoundKey engine.
package ark_pkg;

  localparam int BLOCK_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ark_state_t;

  function automatic int nslice(input int slice_w);
    return BLOCK_W / slice_w;
  endfunction

endpackage

// File: rtl/ark_slice.sv
// One SLICE_W-bit masked XOR: out = data ^ (enable ? key : 0).
module ark_slice #(
  parameter int W = 32
) (
  input  logic [W-1:0] data,
  input  logic [W-1:0] key,
  input  logic         enable,
  output logic [W-1:0] out
);

  assign out = data ^ (key & {W{enable}});

endmodule

// File: rtl/ark_engine.sv
// Sliced AddRoundKey engine: captures a 128-bit block and key, XORs SLICE_W bits per cycle.
// Build option ARK_KEY_ZEROIZE_EN clears the captured key once the last slice is processed.
module ark_engine
  import ark_pkg::*;
#(
  parameter int SLICE_W = 32,
  parameter int OUT_REG = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               ark_enable,
  input  logic [BLOCK_W-1:0] data,
  input  logic [BLOCK_W-1:0] key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] ark_out,
  output logic               busy
);

  localparam int NSLICE = nslice(SLICE_W);
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  if (OUT_REG != 1) begin : g_bad_out_reg
    $error("ark_engine: OUT_REG must be 1");
  end
  if ((BLOCK_W % SLICE_W) != 0) begin : g_bad_slice_w
    $error("ark_engine: SLICE_W must divide 128");
  end

  ark_state_t         state;
  logic [CW-1:0]      cnt;
  logic [BLOCK_W-1:0] data_q;
  logic [BLOCK_W-1:0] key_q;
  logic               en_q;
  logic [BLOCK_W-1:0] res_q;
  logic [BLOCK_W-1:0] res_next;
  logic [7:0]         base;
  logic [SLICE_W-1:0] slice_out;

  assign base = 8'(cnt) * 8'(SLICE_W);

  ark_slice #(.W(SLICE_W)) u_slice (
    .data   (data_q[base +: SLICE_W]),
    .key    (key_q[base +: SLICE_W]),
    .enable (en_q),
    .out    (slice_out)
  );

  always_comb begin
    res_next = res_q;
    res_next[base +: SLICE_W] = slice_out;
  end

  // ark_out is loaded only on entry to DONE so partial results never escape.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      data_q    <= '0;
      key_q     <= '0;
      en_q      <= 1'b0;
      res_q     <= '0;
      ark_out   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            data_q   <= data;
            key_q    <= key;
            en_q     <= ark_enable;
            cnt      <= '0;
            res_q    <= '0;
            state    <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          res_q <= res_next;
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ark_out   <= res_next;
`ifdef ARK_KEY_ZEROIZE_EN
            key_q     <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            ark_out   <= '0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ark_engine.sv
// Directed bench for ark_engine at SLICE_W = 32, 128 and 8.
module tb_ark_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [127:0] d;
  logic [127:0] k;
  logic         iv   [3];
  logic         ordy [3];
  logic         ir   [3];
  logic         ov   [3];
  logic         bz   [3];
  logic [127:0] ao   [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ark_engine #(.SLICE_W(32)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .ark_enable(en),
    .data(d), .key(k), .out_valid(ov[0]), .out_ready(ordy[0]), .ark_out(ao[0]), .busy(bz[0]));
  ark_engine #(.SLICE_W(128)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .ark_enable(en),
    .data(d), .key(k), .out_valid(ov[1]), .out_ready(ordy[1]), .ark_out(ao[1]), .busy(bz[1]));
  ark_engine #(.SLICE_W(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .ark_enable(en),
    .data(d), .key(k), .out_valid(ov[2]), .out_ready(ordy[2]), .ark_out(ao[2]), .busy(bz[2]));

  typedef struct {
    logic         e;
    logic [127:0] dv;
    logic [127:0] kv;
    logic [127:0] xv;
    int           hold;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Called at a negedge with the selected instance idle.
  task automatic run_req(input int inst, input logic e, input logic [127:0] dv,
                         input logic [127:0] kv, input logic [127:0] xv,
                         input int nsl, input int hold, input string nm);
    int lat;
    logic [127:0] kexp;
    chk({nm, " in_ready idle"}, 136'(ir[inst]), 136'(1));
    en = e; d = dv; k = kv; iv[inst] = 1'b1;
    @(negedge clk);
    iv[inst] = 1'b0; d = ~dv; k = ~kv; en = ~e;
    chk({nm, " ark_out hidden"}, 136'(ao[inst]), 136'(0));
    lat = 0;
    while (!ov[inst] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 136'(lat), 136'(nsl));
    chk({nm, " result"}, 136'(ao[inst]), 136'(xv));
    chk({nm, " busy/in_ready in DONE"}, 136'({bz[inst], ir[inst]}), 136'(2'b10));
    if (inst == 0) begin
`ifdef ARK_KEY_ZEROIZE_EN
      kexp = '0;
`else
      kexp = kv;
`endif
      chk({nm, " key reg"}, 136'(u0.key_q), 136'(kexp));
    end
    for (int i = 0; i < hold; i++) begin
      iv[inst] = 1'b1;
      d = {$urandom, $urandom, $urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      en = ~en;
      @(negedge clk);
      chk({nm, " hold stable"}, 136'({ov[inst], ir[inst], ao[inst]}), 136'({2'b10, xv}));
    end
    iv[inst] = 1'b0;
    ordy[inst] = 1'b1;
    @(negedge clk);
    ordy[inst] = 1'b0;
    chk({nm, " after transfer"}, 136'({ov[inst], ir[inst], bz[inst], ao[inst]}),
        136'({3'b010, 128'h0}));
  endtask

  initial begin
    logic seen;
    vecs[0] = '{1'b1, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                128'h00102030405060708090a0b0c0d0e0f0, 0};
    vecs[1] = '{1'b0, 128'h00112233445566778899aabbccddeeff, 128'hffffffffffffffffffffffffffffffff,
                128'h00112233445566778899aabbccddeeff, 0};
    vecs[2] = '{1'b1, 128'h00112233445566778899aabbccddeeff, 128'hffffffffffffffffffffffffffffffff,
                128'hffeeddccbbaa99887766554433221100, 2};
    vecs[3] = '{1'b1, 128'h0, 128'h0123456789abcdeffedcba9876543210,
                128'h0123456789abcdeffedcba9876543210, 10};
    vecs[4] = '{1'b0, 128'h0, 128'h0123456789abcdeffedcba9876543210, 128'h0, 1};

    rst = 1'b1; en = 1'b0; d = '0; k = '0;
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset state u%0d", i), 136'({ov[i], bz[i], ir[i], ao[i]}), 136'({3'b001, 128'h0}));
    chk("reset key reg", 136'(u0.key_q), 136'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      run_req(0, vecs[i].e, vecs[i].dv, vecs[i].kv, vecs[i].xv, 4, vecs[i].hold, $sformatf("vec%0d", i));

    run_req(1, vecs[0].e, vecs[0].dv, vecs[0].kv, vecs[0].xv, 1, 0, "slice128");
    run_req(2, vecs[0].e, vecs[0].dv, vecs[0].kv, vecs[0].xv, 16, 3, "slice8");

    // Abort during slice 2, then a fresh request must still complete.
    en = 1'b1; d = vecs[0].dv; k = vecs[0].kv; iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #2;
    chk("async reset mid-run", 136'({ov[0], bz[0], ir[0], ao[0]}), 136'({3'b001, 128'h0}));
    chk("async reset key reg", 136'(u0.key_q), 136'(0));
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0] || ao[0] != 0) seen = 1'b1;
    end
    chk("no output after abort", 136'(seen), 136'(0));
    run_req(0, vecs[0].e, vecs[0].dv, vecs[0].kv, vecs[0].xv, 4, 0, "post-abort");

    // Back-to-back at minimum spacing on the 32-bit instance.
    run_req(0, vecs[2].e, vecs[2].dv, vecs[2].kv, vecs[2].xv, 4, 0, "b2b-a");
    run_req(0, vecs[1].e, vecs[1].dv, vecs[1].kv, vecs[1].xv, 4, 0, "b2b-b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
